// File: rtl/divider8_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/divider8_if.sv
// Start/ready handshake and operand/result bus of the divider.
interface divider8_if
    import divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             ready;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, a, b,
        input  q, r, ready, done, div_by_zero
    );

    modport slave (
        input  start, a, b,
        output q, r, ready, done, div_by_zero
    );

endinterface

// File: rtl/divider8_div_step.sv
// One restoring division iteration: shift in the next dividend bit, trial-subtract, restore on borrow.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_next_o,
    output logic [WIDTH-1:0] quo_next_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // The partial remainder is always below the divisor, so WIDTH bits hold it
    // between steps; only the shifted trial value needs the extra borrow bit.
    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_i};
        if (trial[WIDTH]) begin
            rem_next_o = shifted[WIDTH-1:0];
            quo_next_o = {quo_i[WIDTH-2:0], 1'b0};
        end else begin
            rem_next_o = trial[WIDTH-1:0];
            quo_next_o = {quo_i[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/divider8.sv
// Sequential unsigned divider: one quotient bit per clock, MSB first, start/ready handshake.
//   state | meaning
//   IDLE  | ready, q/r/div_by_zero hold the last result
//   RUN   | one restoring step per edge, WIDTH steps total
//   DONE  | results just became valid, done pulses for one cycle
module divider8
    import divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic       clk,
    input  logic       rst_n,
    divider8_if.slave  bus
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    div_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i      (rem_q),
        .quo_i      (quo_q),
        .dvs_i      (dvs_q),
        .rem_next_o (rem_next),
        .quo_next_o (quo_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
        end
    end

    // A start in any state restarts; an aborted run never reaches DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;
        if (bus.start) begin
            if (bus.b != '0) begin
                state_d = RUN;
                rem_d   = '0;
                quo_d   = bus.a;
                dvs_d   = bus.b;
                cnt_d   = '0;
                dbz_d   = 1'b0;
            end else begin
                state_d = DONE;
                q_d     = '1;
                r_d     = bus.a;
                dbz_d   = 1'b1;
            end
        end else begin
            case (state_q)
                RUN: begin
                    rem_d = rem_next;
                    quo_d = quo_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) begin
                        q_d     = quo_next;
                        r_d     = rem_next;
                        state_d = DONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.ready       = (state_q != RUN);
        bus.done        = (state_q == DONE);
        bus.q           = q_q;
        bus.r           = r_q;
        bus.div_by_zero = dbz_q;
    end

endmodule

// File: tb/tb_divider8.sv
// Scoreboard bench for divider8: stimulus pushes expected results, a monitor checks each done pulse.
module tb_divider8;
    import divider_pkg::*;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
    } exp_t;

    logic clk;
    logic rst_n;
    divider8_if #(.WIDTH(W)) ifc ();

    divider8 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   done_cnt = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && ifc.start) start_cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (rst_n && ifc.done) begin
            exp_t e;
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("q", ifc.q, e.q);
                check("r", ifc.r, e.r);
                check("div_by_zero", ifc.div_by_zero, e.dbz);
                check("ready_at_done", ifc.ready, 1);
                check("latency", cyc - start_cyc, e.lat);
                if (e.b != 0) begin
                    check("invariant", longint'(ifc.q) * e.b + ifc.r, e.a);
                    check("r_lt_b", (ifc.r < e.b) ? 1 : 0, 1);
                end
            end
        end
    end

    task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        ifc.a = a;
        ifc.b = b;
        ifc.start = 1'b1;
        @(posedge clk);
        #1 ifc.start = 1'b0;
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] q, input logic [W-1:0] r, input logic dbz);
        exp_t e;
        e.a = a; e.b = b; e.q = q; e.r = r; e.dbz = dbz;
        e.lat = dbz ? 0 : W;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("completion_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    typedef struct { logic [W-1:0] a, b, q, r; } vec_t;
    vec_t vecs[6] = '{
        '{8'd255, 8'd255, 8'd1,  8'd0},
        '{8'd254, 8'd255, 8'd0,  8'd254},
        '{8'd200, 8'd13,  8'd15, 8'd5},
        '{8'd128, 8'd2,   8'd64, 8'd0},
        '{8'd1,   8'd1,   8'd1,  8'd0},
        '{8'd0,   8'd5,   8'd0,  8'd0}
    };

    initial begin
        int d0;
        ifc.start = 1'b0;
        ifc.a = '0;
        ifc.b = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_q", ifc.q, 0);
        check("rst_r", ifc.r, 0);
        check("rst_ready", ifc.ready, 1);
        check("rst_done", ifc.done, 0);
        check("rst_dbz", ifc.div_by_zero, 0);
        rst_n = 1'b1;

        push(200, 7, 28, 4, 0);
        do_start(200, 7);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("ready_low_run", ifc.ready, 0);
        end
        wait_idle();

        push(255, 1, 255, 0, 0);
        do_start(255, 1);
        wait_idle();
        push(5, 9, 0, 5, 0);
        do_start(5, 9);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("hold_q", ifc.q, 255);
            check("hold_r", ifc.r, 0);
        end
        wait_idle();

        push(77, 0, 255, 77, 1);
        do_start(77, 0);
        wait_idle();
        check("dbz_held", ifc.div_by_zero, 1);
        push(9, 3, 3, 0, 0);
        do_start(9, 3);
        @(negedge clk);
        check("dbz_cleared", ifc.div_by_zero, 0);
        wait_idle();

        do_start(100, 3);
        repeat (3) @(negedge clk);
        push(50, 6, 8, 2, 0);
        do_start(50, 6);
        wait_idle();

        d0 = done_cnt;
        do_start(90, 4);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrun_rst_q", ifc.q, 0);
        check("midrun_rst_r", ifc.r, 0);
        check("midrun_rst_ready", ifc.ready, 1);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("no_done_after_rst", done_cnt - d0, 0);
        push(90, 4, 22, 2, 0);
        do_start(90, 4);
        wait_idle();

        foreach (vecs[i]) begin
            push(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, 0);
            do_start(vecs[i].a, vecs[i].b);
            wait_idle();
        end

        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(1, 255));
            push(ra, rb, ra / rb, ra % rb, 0);
            do_start(ra, rb);
            wait_idle();
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
